// File: rtl/multi_add_seq_if.sv
// Beat-stream bus for multi_add_seq: input operand beats upstream, result words downstream.
// Upstream source and downstream sink use modport master; multi_add_seq uses modport slave.
interface multi_add_seq_if #(
  parameter int LEN = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [LEN-1:0] a;
  logic [LEN-1:0] b;
  logic           first;
  logic           last;
  logic           sub;
  logic           out_valid;
  logic           out_ready;
  logic [LEN-1:0] y;
  logic           out_last;
  logic           oc;
  logic           ovf;
  logic [7:0]     wcnt;

  modport master (
    output in_valid, a, b, first, last, sub, out_ready,
    input  in_ready, out_valid, y, out_last, oc, ovf, wcnt
  );

  modport slave (
    input  in_valid, a, b, first, last, sub, out_ready,
    output in_ready, out_valid, y, out_last, oc, ovf, wcnt
  );
endinterface

// File: rtl/multi_add_seq.sv
// Word-serial multi-precision add/subtract, LSW first, one-stage output register.
// Define MULTI_ADD_SEQ_OVF_EN to build signed-overflow detection; otherwise ovf is tied to 0.
module multi_add_seq #(
  parameter int LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  multi_add_seq_if.slave    bus
);

  typedef enum logic {IDLE, CHAIN} state_t;

  state_t         state_reg, state_next;
  logic           carry_reg;
  logic           sub_reg;
  logic           out_valid_reg;
  logic           out_last_reg;
  logic [LEN-1:0] y_reg;
  logic [7:0]     wcnt_reg;

  logic           accept;
  logic           start;
  logic           sub_eff;
  logic           cin;
  logic [LEN-1:0] b_eff;
  logic [LEN:0]   sum;

  assign bus.in_ready = !out_valid_reg | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A beat opens a new operation when flagged FIRST or when nothing is open.
  always_comb begin
    state_next = state_reg;
    start      = bus.first | (state_reg == IDLE);
    sub_eff    = start ? bus.sub : sub_reg;
    cin        = start ? bus.sub : carry_reg;
    b_eff      = sub_eff ? ~bus.b : bus.b;
    sum        = {1'b0, bus.a} + {1'b0, b_eff} + {{LEN{1'b0}}, cin};
    if (accept) begin
      state_next = bus.last ? IDLE : CHAIN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_reg     <= 1'b0;
      sub_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      y_reg         <= '0;
      wcnt_reg      <= 8'd0;
    end else if (accept) begin
      carry_reg     <= sum[LEN];
      out_valid_reg <= 1'b1;
      out_last_reg  <= bus.last;
      y_reg         <= sum[LEN-1:0];
      if (start) begin
        sub_reg  <= bus.sub;
        wcnt_reg <= 8'd1;
      end else if (wcnt_reg != 8'd255) begin
        wcnt_reg <= wcnt_reg + 8'd1;
      end
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

`ifdef MULTI_ADD_SEQ_OVF_EN
  logic ovf_reg;
  logic msb_cin;

  // Overflow = carry into MSB differs from carry out of MSB.
  assign msb_cin = bus.a[LEN-1] ^ b_eff[LEN-1] ^ sum[LEN-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (accept) begin
      ovf_reg <= msb_cin ^ sum[LEN];
    end
  end

  assign bus.ovf = out_valid_reg & out_last_reg & ovf_reg;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.out_valid = out_valid_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.y         = y_reg;
  assign bus.oc        = out_valid_reg & out_last_reg & carry_reg;
  assign bus.wcnt      = wcnt_reg;

endmodule
